// File: rtl/fas_pkg.sv
// Shared constants and operation encoding for the registered add/subtract block.
package fas_pkg;

  localparam int FAS_WIDTH_DEFAULT = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fas_op_e;

endpackage

// File: rtl/fas_full_adder.sv
// One-bit full adder cell, chained by fas into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/fas.sv
// Registered WIDTH-bit ripple-carry adder/subtractor.
// Subtraction is A + ~B + 1, so Cout doubles as the "no borrow" flag.
module fas
  import fas_pkg::*;
#(
  parameter int WIDTH = FAS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Selecting subtract inverts B and injects the +1 through the carry-in.
  assign w_b_op     = B ^ {WIDTH{S == OP_SUB}};
  assign w_carry[0] = S;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (w_b_op[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_fas.sv
// Self-checking bench for fas: directed vector table, reset/hold sequences, random vs. arithmetic model.
module tb_fas;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       S;
  logic [7:0] Sum;
  logic       Cout;

  int n_pass  = 0;
  int n_total = 0;

  fas #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .S    (S),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got Cout,Sum=%0h expected %0h", name, act, exp);
  endtask

  // Reference: plain unsigned arithmetic, independent of the gate-level formulation.
  function automatic logic [8:0] model(input logic r, input logic [7:0] a,
                                       input logic [7:0] b, input logic s);
    int unsigned res;
    logic        flag;
    if (r) return 9'd0;
    if (!s) begin
      res  = int'(a) + int'(b);
      flag = (res >= 256);
    end else begin
      res  = (int'(a) - int'(b) + 256) % 256;
      flag = (a >= b);
    end
    return {flag, res[7:0]};
  endfunction

  task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    S   = s;
  endtask

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    A   = '0;
    B   = '0;
    S   = 1'b0;

    vecs[0] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h0A, 8'h09, 1'b0, 8'h13, 1'b0};
    vecs[3] = '{1'b0, 8'h0A, 8'h09, 1'b1, 8'h01, 1'b1};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1};
    vecs[7] = '{1'b0, 8'h55, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].s);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {Cout, Sum}, {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // Outputs must hold between edges even when inputs change.
    drive(1'b0, 8'h01, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    check("hold_load", {Cout, Sum}, {1'b0, 8'h02});
    drive(1'b0, 8'hF0, 8'h20, 1'b0);
    #2;
    check("hold_between_edges", {Cout, Sum}, {1'b0, 8'h02});
    @(posedge clk);
    #1;
    check("hold_next_edge", {Cout, Sum}, {1'b1, 8'h10});

    // Back-to-back with reset in the middle of the stream.
    drive(1'b0, 8'h0A, 8'h09, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_add", {Cout, Sum}, {1'b0, 8'h13});
    drive(1'b1, 8'h0A, 8'h09, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_reset", {Cout, Sum}, {1'b0, 8'h00});
    drive(1'b0, 8'h03, 8'h05, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_post_reset", {Cout, Sum}, {1'b0, 8'hFE});
    drive(1'b0, 8'h05, 8'h03, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_sub", {Cout, Sum}, {1'b1, 8'h02});

    // Random stream, one op per cycle, occasional reset.
    for (int i = 0; i < 1000; i++) begin
      logic       r;
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      r = ($urandom_range(0, 49) == 0);
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      drive(r, a, b, s);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), {Cout, Sum}, model(r, a, b, s));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
